// File: rtl/ibex_rf_ctx_sequencer.sv
// Context save/restore sequencer: streams x1..xLAST out of the register file, or writes them back from a stream.
// Latency: save word k is valid 2k cycles after the request; restore word k is written k cycles after the request.
// Backpressure: out_ready_i low holds the save word stable; in_valid_i low stalls restore with no write.
module ibex_rf_ctx_sequencer #(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 93
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 save_req_i,
  input  logic                 restore_req_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [4:0]           rf_raddr_o,
  input  logic [DataWidth-1:0] rf_rdata_i,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 rf_we_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_data_o,
  output logic                 out_last_o,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DataWidth-1:0] in_data_i
);

  // Highest architectural register index; x0 is never touched.
  localparam logic [4:0] LAST = RV32E ? 5'd15 : 5'd31;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SAVE_RD  = 3'd1,
    SAVE_OUT = 3'd2,
    RESTORE  = 3'd3,
    DONE     = 3'd4
  } state_e;

  state_e               r_state;
  logic [4:0]           r_idx;
  logic [DataWidth-1:0] r_out_data;
  logic                 r_out_valid;
  logic                 r_out_last;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_restore;
  logic                 w_idx_last;

  assign w_restore  = (r_state == RESTORE);
  assign w_idx_last = (r_idx == LAST);

  // Sequencer FSM; stream and status outputs are registered alongside the state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_idx       <= 5'd0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // Save wins a tie; requests outside IDLE are simply dropped.
          if (save_req_i) begin
            r_state <= SAVE_RD;
            r_idx   <= 5'd1;
            r_busy  <= 1'b1;
          end else if (restore_req_i) begin
            r_state <= RESTORE;
            r_idx   <= 5'd1;
            r_busy  <= 1'b1;
          end
        end
        SAVE_RD: begin
          if (abort_i) begin
            r_state <= IDLE;
            r_idx   <= 5'd0;
            r_busy  <= 1'b0;
          end else begin
            r_out_data  <= rf_rdata_i;
            r_out_valid <= 1'b1;
            r_out_last  <= w_idx_last;
            r_state     <= SAVE_OUT;
          end
        end
        SAVE_OUT: begin
          if (abort_i) begin
            // Partial stream is abandoned; valid drops without a handshake.
            r_state     <= IDLE;
            r_idx       <= 5'd0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
          end else if (out_ready_i) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (w_idx_last) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx   <= r_idx + 5'd1;
              r_state <= SAVE_RD;
            end
          end
        end
        RESTORE: begin
          if (abort_i) begin
            r_state <= IDLE;
            r_idx   <= 5'd0;
            r_busy  <= 1'b0;
          end else if (in_valid_i) begin
            if (w_idx_last) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + 5'd1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state     <= IDLE;
          r_idx       <= 5'd0;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end
      endcase
    end
  end

  // Register-file ports are combinational from the state so reads and writes land in the owning cycle.
  assign rf_raddr_o  = (r_state == SAVE_RD) ? r_idx : 5'd0;
  assign rf_waddr_o  = w_restore ? r_idx : 5'd0;
  assign rf_wdata_o  = w_restore ? in_data_i : '0;
  assign rf_we_o     = w_restore & in_valid_i & ~abort_i;
  assign in_ready_o  = w_restore;

  assign out_valid_o = r_out_valid;
  assign out_last_o  = r_out_last;
  assign out_data_o  = r_out_data;
  assign busy_o      = r_busy;
  assign done_o      = r_done;

endmodule

// File: tb/tb_ibex_rf_ctx_sequencer.sv
// Bench for ibex_rf_ctx_sequencer: instance 0 is the 32-entry file, instance 1 the RV32E file.
// Stimulus tasks push expected words, writes and done cycles; per-instance monitors pop and compare.
// Register file is modelled as a fixed data pattern per address; writes are checked against the queue.
module tb_ibex_rf_ctx_sequencer;

  localparam int DW = 93;

  typedef struct {
    logic [DW-1:0] d;
    logic          last;
    int            cyc;
  } out_t;

  typedef struct {
    logic [4:0]    a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    save_req, restore_req, abort, out_ready, in_valid;
  logic [1:0]    busy, done, rf_we, out_valid, out_last, in_ready;
  logic [4:0]    raddr [2];
  logic [4:0]    waddr [2];
  logic [DW-1:0] rdata [2];
  logic [DW-1:0] wdata [2];
  logic [DW-1:0] out_data [2];
  logic [DW-1:0] in_data [2];

  int   cyc = 0;
  int   pat = 0;
  int   n_chk = 0;
  int   n_err = 0;
  out_t q_out[$];
  wr_t  q_wr[$];
  int   q_done[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register-file contents: pattern 0 holds the index (x31 all ones), pattern 1 a scrambled value.
  function automatic logic [DW-1:0] word(input int p, input logic [4:0] a);
    logic [DW-1:0] v;
    v = {{(DW-5){1'b0}}, a};
    if (p == 0) begin
      if (a == 5'd31) v = '1;
    end else begin
      v = (v << 70) | DW'(32'h5A00 + 32'(a));
    end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s", nm);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ibex_rf_ctx_sequencer #(.RV32E(g == 1), .DataWidth(DW)) u_dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .save_req_i   (save_req[g]),
      .restore_req_i(restore_req[g]),
      .abort_i      (abort[g]),
      .busy_o       (busy[g]),
      .done_o       (done[g]),
      .rf_raddr_o   (raddr[g]),
      .rf_rdata_i   (rdata[g]),
      .rf_waddr_o   (waddr[g]),
      .rf_wdata_o   (wdata[g]),
      .rf_we_o      (rf_we[g]),
      .out_valid_o  (out_valid[g]),
      .out_ready_i  (out_ready[g]),
      .out_data_o   (out_data[g]),
      .out_last_o   (out_last[g]),
      .in_valid_i   (in_valid[g]),
      .in_ready_o   (in_ready[g]),
      .in_data_i    (in_data[g])
    );

    assign rdata[g] = word(pat, raddr[g]);

    logic          stall = 1'b0;
    logic [DW-1:0] held = '0;

    // Monitor: pops the scoreboard whenever this instance presents done, a save handshake or a write.
    always @(negedge clk) begin
      if (done[g]) begin
        chk("busy_with_done", {127'd0, busy[g]}, 128'd0);
        if (q_done.size() == 0) fail("unexpected_done");
        else begin
          if (q_done[0] >= 0) chk("done_cycle", 128'(cyc), 128'(q_done[0]));
          void'(q_done.pop_front());
        end
      end
      if (out_last[g] && !out_valid[g]) fail("last_without_valid");
      if (stall && out_valid[g]) chk("stall_data_stable", 128'(out_data[g]), 128'(held));
      if (out_valid[g] && out_ready[g] && !abort[g]) begin
        if (q_out.size() == 0) fail("unexpected_save_word");
        else begin
          chk("save_data", 128'(out_data[g]), 128'(q_out[0].d));
          chk("save_last", {127'd0, out_last[g]}, {127'd0, q_out[0].last});
          if (q_out[0].cyc >= 0) chk("save_cycle", 128'(cyc), 128'(q_out[0].cyc));
          void'(q_out.pop_front());
        end
      end
      if (rf_we[g]) begin
        if (q_wr.size() == 0) fail("unexpected_rf_write");
        else begin
          chk("wr_addr", 128'(waddr[g]), 128'(q_wr[0].a));
          chk("wr_data", 128'(wdata[g]), 128'(q_wr[0].d));
          void'(q_wr.pop_front());
        end
      end
      stall <= out_valid[g] & ~out_ready[g] & ~abort[g];
      held  <= out_data[g];
    end
  end

  task automatic check_zero(input int d);
    chk("z_busy", {127'd0, busy[d]}, 128'd0);
    chk("z_done", {127'd0, done[d]}, 128'd0);
    chk("z_out_valid", {127'd0, out_valid[d]}, 128'd0);
    chk("z_out_last", {127'd0, out_last[d]}, 128'd0);
    chk("z_in_ready", {127'd0, in_ready[d]}, 128'd0);
    chk("z_rf_we", {127'd0, rf_we[d]}, 128'd0);
    chk("z_raddr", 128'(raddr[d]), 128'd0);
    chk("z_waddr", 128'(waddr[d]), 128'd0);
    chk("z_wdata", 128'(wdata[d]), 128'd0);
    chk("z_out_data", 128'(out_data[d]), 128'd0);
  endtask

  task automatic settle_idle(input int d);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_op", {127'd0, busy[d]}, 128'd0);
  endtask

  task automatic do_save(input int d, input int n, input int p, input bit both, input bit bp,
                         input int abort_k, input int pulse_i);
    int   c0;
    int   i;
    out_t e;
    @(posedge clk); #1;
    pat = p;
    save_req[d] = 1'b1;
    restore_req[d] = both;
    out_ready[d] = 1'b1;
    c0 = cyc;
    for (int k = 1; k <= n; k++) begin
      if (abort_k == 0 || k < abort_k) begin
        e.d = word(p, 5'(k));
        e.last = (k == n);
        e.cyc = bp ? -1 : c0 + 2 * k;
        q_out.push_back(e);
      end
    end
    if (abort_k == 0) q_done.push_back(bp ? -1 : c0 + 2 * n + 1);
    @(posedge clk); #1;
    save_req[d] = 1'b0;
    restore_req[d] = 1'b0;
    i = 1;
    while (q_out.size() != 0 || q_done.size() != 0 || abort_k != 0) begin
      out_ready[d] = bp ? ((i * 5) % 7 < 3) : 1'b1;
      restore_req[d] = (i == pulse_i);
      if (abort_k != 0 && cyc == c0 + 2 * abort_k) begin
        chk("valid_before_abort", {127'd0, out_valid[d]}, 128'd1);
        out_ready[d] = 1'b0;
        abort[d] = 1'b1;
        @(posedge clk); #1;
        abort[d] = 1'b0;
        chk("abort_valid_drop", {127'd0, out_valid[d]}, 128'd0);
        chk("abort_busy_drop", {127'd0, busy[d]}, 128'd0);
        break;
      end
      if (i > 400) begin
        fail("save_timeout");
        break;
      end
      @(posedge clk); #1;
      i++;
    end
    restore_req[d] = 1'b0;
    out_ready[d] = 1'b0;
    settle_idle(d);
  endtask

  task automatic do_restore(input int d, input int n, input bit gaps, input int abort_k, input int rst_k);
    int  k;
    int  i;
    wr_t w;
    @(posedge clk); #1;
    restore_req[d] = 1'b1;
    @(posedge clk); #1;
    restore_req[d] = 1'b0;
    k = 1;
    i = 1;
    while (k <= n) begin
      in_data[d] = DW'(32'h100 + k);
      in_valid[d] = !(gaps && (i % 3 == 0));
      if (k == abort_k) begin
        in_valid[d] = 1'b1;
        abort[d] = 1'b1;
        @(posedge clk); #1;
        abort[d] = 1'b0;
        in_valid[d] = 1'b0;
        chk("restore_abort_busy", {127'd0, busy[d]}, 128'd0);
        chk("restore_abort_ready", {127'd0, in_ready[d]}, 128'd0);
        break;
      end
      if (k == rst_k) begin
        in_valid[d] = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        break;
      end
      if (in_valid[d]) begin
        w.a = 5'(k);
        w.d = in_data[d];
        q_wr.push_back(w);
        if (k == n) q_done.push_back(cyc + 1);
        k++;
      end
      if (i > 200) begin
        fail("restore_timeout");
        break;
      end
      @(posedge clk); #1;
      i++;
    end
    in_valid[d] = 1'b0;
    if (rst_k == 0) settle_idle(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    save_req = '0;
    restore_req = '0;
    abort = '0;
    out_ready = '0;
    in_valid = '0;
    in_data[0] = '0;
    in_data[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero(0);
    check_zero(1);
    rst_n = 1'b1;

    do_save(0, 31, 0, 1'b0, 1'b0, 0, 0);    // full save, ready held high
    do_save(0, 31, 1, 1'b0, 1'b1, 0, 0);    // save with backpressure
    do_restore(0, 31, 1'b1, 0, 0);          // restore with every third cycle idle
    do_save(0, 31, 0, 1'b1, 1'b0, 0, 10);   // simultaneous requests, restore pulsed while busy
    do_save(0, 31, 0, 1'b0, 1'b0, 10, 0);   // abort while word 10 is presented
    do_restore(0, 31, 1'b0, 5, 0);          // abort while word 5 is offered

    do_save(1, 15, 0, 1'b0, 1'b0, 0, 0);    // RV32E save
    do_restore(1, 15, 1'b0, 0, 0);          // RV32E restore
    do_restore(1, 15, 1'b0, 0, 4);          // reset in the middle of a restore
    rst_n = 1'b1;
    in_valid[1] = 1'b1;
    in_data[1] = DW'(32'h1FF);
    #1;
    check_zero(1);
    in_valid[1] = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    chk("q_out_drained", 128'(q_out.size()), 128'd0);
    chk("q_wr_drained", 128'(q_wr.size()), 128'd0);
    chk("q_done_drained", 128'(q_done.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
